// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline memory-access stage.
package pipe_pkg;

  localparam int REGNUM_W = 5;
  localparam int WORD_W   = 32;

  localparam logic [WORD_W-1:0] ERR_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} mem_state_t;

  // Data memory is word addressed; byte offset bits are dropped.
  function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_W-1:0] a);
    return {a[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pipe_mem_stage_mwreg.sv
// MEM/WB pipeline register: full load, or bubble (clear write controls, hold data).
// One-cycle latency; reset clears every field.
module pipemwreg
  import pipe_pkg::*;
(
  input  logic                clock,
  input  logic                resetn,
  input  logic                i_load,
  input  logic                i_bubble,
  input  logic                i_wreg,
  input  logic                i_m2reg,
  input  logic [WORD_W-1:0]   i_mo,
  input  logic [WORD_W-1:0]   i_alu,
  input  logic [REGNUM_W-1:0] i_rn,
  output logic                o_wreg,
  output logic                o_m2reg,
  output logic [WORD_W-1:0]   o_mo,
  output logic [WORD_W-1:0]   o_alu,
  output logic [REGNUM_W-1:0] o_rn
);

  logic                r_wreg;
  logic                r_m2reg;
  logic [WORD_W-1:0]   r_mo;
  logic [WORD_W-1:0]   r_alu;
  logic [REGNUM_W-1:0] r_rn;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_wreg  <= 1'b0;
      r_m2reg <= 1'b0;
      r_mo    <= '0;
      r_alu   <= '0;
      r_rn    <= '0;
    end else if (i_bubble) begin
      r_wreg  <= 1'b0;
      r_m2reg <= 1'b0;
    end else if (i_load) begin
      r_wreg  <= i_wreg;
      r_m2reg <= i_m2reg;
      r_mo    <= i_mo;
      r_alu   <= i_alu;
      r_rn    <= i_rn;
    end
  end

  assign o_wreg  = r_wreg;
  assign o_m2reg = r_m2reg;
  assign o_mo    = r_mo;
  assign o_alu   = r_alu;
  assign o_rn    = r_rn;

endmodule

// File: rtl/pipe_mem_stage.sv
// Memory-access stage: EX/MEM -> req/gnt/valid data bus -> MEM/WB; stalls the pipe while an access is open.
// MEM_TIMEOUT_EN adds an abort after TIMEOUT_CYCLES in REQ/RESP, pulsing merr and writing ERR_DATA.
module pipe_mem_stage
  import pipe_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
)
(
  input  logic                clock,
  input  logic                resetn,
  input  logic                mwreg,
  input  logic                mm2reg,
  input  logic                mwmem,
  input  logic [WORD_W-1:0]   malu,
  input  logic [WORD_W-1:0]   mb,
  input  logic [REGNUM_W-1:0] mrn,
  output logic                dreq,
  output logic                dwe,
  output logic [WORD_W-1:0]   daddr,
  output logic [WORD_W-1:0]   dwdata,
  input  logic                dgnt,
  input  logic                dvalid,
  input  logic [WORD_W-1:0]   drdata,
  output logic                mstall,
  output logic                merr,
  output logic                wwreg,
  output logic                wm2reg,
  output logic [WORD_W-1:0]   wmo,
  output logic [WORD_W-1:0]   walu,
  output logic [REGNUM_W-1:0] wrn
);

  mem_state_t        r_state;
  logic [WORD_W-1:0] r_rdata;

  logic w_acc;
  logic w_req;
  logic w_stall;
  logic w_fin;
  logic w_latch;
  logic w_err;

  // A combined load+store is treated as a store.
  assign w_acc = mm2reg | mwmem;

  always_comb begin
    w_req   = 1'b0;
    w_stall = 1'b0;
    case (r_state)
      IDLE: begin
        w_req   = w_acc;
        w_stall = w_acc;
      end
      REQ: begin
        w_req   = 1'b1;
        w_stall = 1'b1;
      end
      RESP:    w_stall = 1'b1;
      default: w_stall = 1'b0;
    endcase
  end

  // Read data is only trusted once the request has been granted.
  assign w_latch = dvalid & ((w_req & dgnt & ~mwmem) | (r_state == RESP));
  assign w_fin   = (w_req & dgnt & mwmem) | w_latch;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_merr;
  logic             w_wait;
  logic             w_expire;

  assign w_wait   = (r_state == REQ) | (r_state == RESP);
  assign w_expire = w_wait & ~w_fin & (r_cnt == CNT_LAST);
  assign w_err    = r_merr;
`else
  assign w_err    = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_rdata <= '0;
`ifdef MEM_TIMEOUT_EN
      r_cnt   <= '0;
      r_merr  <= 1'b0;
`endif
    end else begin
      if (w_latch)
        r_rdata <= drdata;
      case (r_state)
        IDLE, REQ: begin
          if (w_req) begin
            if (w_fin)
              r_state <= DONE;
            else if (dgnt)
              r_state <= RESP;
            else
              r_state <= REQ;
          end
        end
        RESP: begin
          if (dvalid)
            r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
`ifdef MEM_TIMEOUT_EN
      r_merr <= 1'b0;
      if (r_state == IDLE)
        r_cnt <= '0;
      else if (w_wait)
        r_cnt <= r_cnt + 1'b1;
      // Late assignments override the normal transition on expiry.
      if (w_expire) begin
        r_state <= DONE;
        r_rdata <= ERR_DATA;
        r_merr  <= 1'b1;
      end
`endif
    end
  end

  assign dreq   = w_req & resetn;
  assign dwe    = w_req & mwmem & resetn;
  assign mstall = w_stall & resetn;
  assign daddr  = word_addr(malu);
  assign dwdata = mb;
  assign merr   = w_err;

  pipemwreg u_mwreg (
    .clock    (clock),
    .resetn   (resetn),
    .i_load   (~w_stall),
    .i_bubble (w_stall),
    .i_wreg   (mwreg & ~w_err),
    .i_m2reg  (mm2reg & ~mwmem),
    .i_mo     ((r_state == DONE) ? r_rdata : '0),
    .i_alu    (malu),
    .i_rn     (mrn),
    .o_wreg   (wwreg),
    .o_m2reg  (wm2reg),
    .o_mo     (wmo),
    .o_alu    (walu),
    .o_rn     (wrn)
  );

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Directed plus randomized bench for pipe_mem_stage against a transaction-level model.
module tb_pipe_mem_stage;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        mwreg = 1'b0, mm2reg = 1'b0, mwmem = 1'b0;
  logic [31:0] malu = '0, mb = '0;
  logic [4:0]  mrn = '0;
  logic        dreq, dwe;
  logic [31:0] daddr, dwdata;
  logic        dgnt = 1'b0, dvalid = 1'b0;
  logic [31:0] drdata = '0;
  logic        mstall, merr, wwreg, wm2reg;
  logic [31:0] wmo, walu;
  logic [4:0]  wrn;

  int checks = 0;
  int failures = 0;

  // Model state: last read data seen by the stage and the expected MEM/WB contents.
  logic [31:0] model_latch = '0;
  logic [31:0] exp_wmo = '0, exp_walu = '0;
  logic [4:0]  exp_wrn = '0;

  always #5 clock = ~clock;

  pipe_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clock  (clock),
    .resetn (resetn),
    .mwreg  (mwreg),
    .mm2reg (mm2reg),
    .mwmem  (mwmem),
    .malu   (malu),
    .mb     (mb),
    .mrn    (mrn),
    .dreq   (dreq),
    .dwe    (dwe),
    .daddr  (daddr),
    .dwdata (dwdata),
    .dgnt   (dgnt),
    .dvalid (dvalid),
    .drdata (drdata),
    .mstall (mstall),
    .merr   (merr),
    .wwreg  (wwreg),
    .wm2reg (wm2reg),
    .wmo    (wmo),
    .walu   (walu),
    .wrn    (wrn)
  );

  task automatic chk1(input string tag, input logic obs, input logic want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, want);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_wb(input string tag, input logic want_wreg, input logic want_m2reg);
    chk1({tag, "_wwreg"}, wwreg, want_wreg);
    chk1({tag, "_wm2reg"}, wm2reg, want_m2reg);
    chk32({tag, "_wmo"}, wmo, exp_wmo);
    chk32({tag, "_walu"}, walu, exp_walu);
    chk32({tag, "_wrn"}, 32'(wrn), 32'(exp_wrn));
  endtask

  // Non-memory instruction; bus noise in IDLE must not matter.
  task automatic alu_op(input logic wreg, input logic [31:0] alu, input logic [4:0] rn);
    mwreg = wreg; mm2reg = 1'b0; mwmem = 1'b0;
    malu = alu; mb = $urandom; mrn = rn;
    dgnt = 1'($urandom); dvalid = 1'($urandom); drdata = $urandom;
    #1;
    chk1("alu_mstall", mstall, 1'b0);
    chk1("alu_dreq", dreq, 1'b0);
    tick();
    dgnt = 1'b0; dvalid = 1'b0;
    exp_wmo = '0; exp_walu = alu; exp_wrn = rn;
    check_wb("alu", wreg, 1'b0);
  endtask

  // Memory access: grant after g cycles, read data d cycles after the grant.
  task automatic do_access(input logic wreg, input logic m2reg, input logic wmem,
                           input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rn,
                           input int g, input int d, input logic [31:0] rdata);
    int len;
    len = wmem ? g + 1 : g + d + 1;
    mwreg = wreg; mm2reg = m2reg; mwmem = wmem; malu = alu; mb = b; mrn = rn;
    for (int c = 0; c <= len; c++) begin
      dgnt = (c == g);
      if (c < g)
        dvalid = 1'($urandom);
      else
        dvalid = !wmem && (c == g + d);
      drdata = (!wmem && c == g + d) ? rdata : $urandom;
      #1;
      chk1("acc_mstall", mstall, c < len);
      chk1("acc_dreq", dreq, c <= g);
      chk1("acc_merr", merr, 1'b0);
      if (c <= g) begin
        chk1("acc_dwe", dwe, wmem);
        chk32("acc_daddr", daddr, alu & 32'hFFFF_FFFC);
        chk32("acc_dwdata", dwdata, b);
      end
      tick();
      if (c < len)
        check_wb("bubble", 1'b0, 1'b0);
    end
    dgnt = 1'b0; dvalid = 1'b0;
    if (!wmem)
      model_latch = rdata;
    exp_wmo = model_latch; exp_walu = alu; exp_wrn = rn;
    check_wb("acc_wb", wreg, m2reg & !wmem);
  endtask

  initial begin
    tick();
    tick();
    // Access request presented during reset must be gated off.
    mm2reg = 1'b1; mwmem = 1'b1;
    #1;
    chk1("rst_mstall", mstall, 1'b0);
    chk1("rst_dreq", dreq, 1'b0);
    chk1("rst_dwe", dwe, 1'b0);
    chk1("rst_merr", merr, 1'b0);
    check_wb("rst", 1'b0, 1'b0);
    mm2reg = 1'b0; mwmem = 1'b0; resetn = 1'b1;
    tick();

    alu_op(1'b1, 32'h12, 5'd5);
    do_access(1'b0, 1'b0, 1'b1, 32'h103, 32'hA5, 5'd0, 0, 0, 32'h0);
    do_access(1'b1, 1'b1, 1'b0, 32'h2000, 32'h1111, 5'd7, 2, 3, 32'hCAFE);
    do_access(1'b1, 1'b1, 1'b1, 32'h3006, 32'h5A5A, 5'd9, 1, 0, 32'h0);

    // Reset while waiting for read data; a late dvalid must be ignored.
    mwreg = 1'b1; mm2reg = 1'b1; mwmem = 1'b0; malu = 32'h440; mrn = 5'd3;
    dgnt = 1'b1; dvalid = 1'b0;
    #1;
    chk1("rr_mstall0", mstall, 1'b1);
    tick();
    dgnt = 1'b0;
    #1;
    chk1("rr_dreq_resp", dreq, 1'b0);
    chk1("rr_mstall_resp", mstall, 1'b1);
    tick();
    resetn = 1'b0;
    #1;
    chk1("rr_mstall_gated", mstall, 1'b0);
    tick();
    model_latch = '0; exp_wmo = '0; exp_walu = '0; exp_wrn = '0;
    check_wb("rr_reset", 1'b0, 1'b0);
    resetn = 1'b1;
    mwreg = 1'b0; mm2reg = 1'b0; malu = '0; mrn = '0;
    dvalid = 1'b1; drdata = 32'hBAD0BAD0;
    #1;
    chk1("rr_mstall_after", mstall, 1'b0);
    chk1("rr_dreq_after", dreq, 1'b0);
    tick();
    dvalid = 1'b0;
    check_wb("rr_late_dvalid", 1'b0, 1'b0);
    alu_op(1'b1, 32'h77, 5'd12);
    do_access(1'b1, 1'b0, 1'b1, 32'h8, 32'h9, 5'd1, 0, 0, 32'h0);

`ifdef MEM_TIMEOUT_EN
    // Grant never comes: abort on the fifth cycle after the request.
    mwreg = 1'b1; mm2reg = 1'b1; mwmem = 1'b0; malu = 32'h600; mrn = 5'd4;
    dgnt = 1'b0; dvalid = 1'b0;
    for (int c = 0; c <= 5; c++) begin
      #1;
      chk1("to_merr", merr, c == 5);
      chk1("to_mstall", mstall, c < 5);
      tick();
    end
    model_latch = 32'hDEADBEEF;
    exp_wmo = model_latch; exp_walu = 32'h600; exp_wrn = 5'd4;
    check_wb("to_wb", 1'b0, 1'b1);
    #1;
    mm2reg = 1'b0;
    chk1("to_merr_clear", merr, 1'b0);
    alu_op(1'b1, 32'h99, 5'd6);
`endif

    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = $urandom_range(0, 3);
      if (kind == 0)
        alu_op(1'($urandom), $urandom, 5'($urandom));
      else
        do_access(1'($urandom), kind != 2, kind != 1, $urandom, $urandom, 5'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
